// File: rtl/jk_cmd_arbiter_if.sv
// Command/bank interface for jk_cmd_arbiter: requester handshake, JK bank
// drive, shadow state and readback.
interface jk_cmd_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_mask;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      jk_j;
  logic [WIDTH-1:0]      jk_k;
  logic                  busy;
  logic [GW-1:0]         grant_id;
  logic [WIDTH-1:0]      shadow_q;
  logic [WIDTH-1:0]      q_i;
  logic                  mismatch;

  // Requester / bank side
  modport master (
    output req_valid, req_op, req_mask, q_i,
    input  req_ready, jk_j, jk_k, busy, grant_id, shadow_q, mismatch
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_op, req_mask, q_i,
    output req_ready, jk_j, jk_k, busy, grant_id, shadow_q, mismatch
  );
endinterface

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter sharing one bank of master-slave JK flip-flops among
// NREQ requesters. Each granted op becomes a one-cycle j/k pulse followed by
// SETTLE idle cycles; a shadow register tracks the expected bank contents.
// Optional feature macro: JKARB_READBACK_EN (compare q_i against the shadow
// at the end of each slot, sticky mismatch flag).
module jk_cmd_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input logic            clk,
  input logic            rst,
  jk_cmd_arbiter_if.slave bus
);

  localparam int unsigned GW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SLAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [GW-1:0] GLAST = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [GW-1:0]    ptr, ptr_d;
  logic [GW-1:0]    grant, grant_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] jk_j, jk_j_d;
  logic [WIDTH-1:0] jk_k, jk_k_d;
  logic             busy, busy_d;
  logic [WIDTH-1:0] shadow, shadow_d;
  logic [NREQ-1:0]  ready_c;
  logic             pick_found;
  logic [GW-1:0]    pick_idx;
  logic [GW:0]      cand;
  logic             last_cycle;

  logic [1:0]       op_arr   [NREQ];
  logic [WIDTH-1:0] mask_arr [NREQ];

  // Unpack the flat request buses into per-requester fields
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g]   = bus.req_op[2*g +: 2];
    assign mask_arr[g] = bus.req_mask[WIDTH*g +: WIDTH];
  end

  // Final cycle of a slot: end of ISSUE when there is no settle time, else last SETTLE cycle
  assign last_cycle = ((state == ST_ISSUE) && (SETTLE == 0)) ||
                      ((state == ST_SETTLE) && (cnt == CW'(SLAST)));

  // Round-robin search: first valid requester at or above ptr, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (GW+1)'(i);
      if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
      if (!pick_found && bus.req_valid[GW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  // Next-state and next-output logic for the IDLE/ISSUE/SETTLE sequencer
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    grant_d  = grant;
    cnt_d    = cnt;
    jk_j_d   = '0;
    jk_k_d   = '0;
    busy_d   = busy;
    shadow_d = shadow;
    ready_c  = '0;
    unique case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (pick_found && !rst) begin
          ready_c[pick_idx] = 1'b1;
          grant_d = pick_idx;
          ptr_d   = (pick_idx == GLAST) ? '0 : pick_idx + GW'(1);
          jk_j_d  = mask_arr[pick_idx] & {WIDTH{op_arr[pick_idx][1]}};
          jk_k_d  = mask_arr[pick_idx] & {WIDTH{op_arr[pick_idx][0]}};
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // JK characteristic equation; unmasked bits see j=k=0 and hold
        shadow_d = (jk_j & ~shadow) | (~jk_k & shadow);
        cnt_d    = '0;
        if (last_cycle) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (last_cycle) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      grant  <= '0;
      cnt    <= '0;
      jk_j   <= '0;
      jk_k   <= '0;
      busy   <= 1'b0;
      shadow <= '0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      grant  <= grant_d;
      cnt    <= cnt_d;
      jk_j   <= jk_j_d;
      jk_k   <= jk_k_d;
      busy   <= busy_d;
      shadow <= shadow_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.jk_j      = jk_j;
  assign bus.jk_k      = jk_k;
  assign bus.busy      = busy;
  assign bus.grant_id  = grant;
  assign bus.shadow_q  = shadow;

`ifdef JKARB_READBACK_EN
  logic mismatch_r;

  // Sticky readback check; shadow_d equals the post-op shadow on the final slot cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_r <= 1'b0;
    end else if (last_cycle && (bus.q_i != shadow_d)) begin
      mismatch_r <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_r;
`else
  logic unused_q_i;

  assign unused_q_i   = ^bus.q_i;
  assign bus.mismatch = 1'b0;
`endif

endmodule
